// File: rtl/dev_dumper_pkg.sv
// Shared types, ASCII constants and the hex-digit helper for the memory dump engine.
// Optional feature macro: DEV_DUMPER_ADDR_PREFIX_EN adds the address-prefix states.
package dev_dumper_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
    S_ADDR,
    S_COLON,
    S_SPACE,
`endif
    S_FETCH,
    S_WAIT,
    S_EMIT_HI,
    S_EMIT_LO,
    S_EMIT_SEP,
    S_DONE
  } dumper_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  // Map a 4-bit value to its uppercase ASCII hex digit.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h41 + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/dev_dumper_emit.sv
// Push pacing for the dump engine: turns a held character request into single,
// spaced tx_push pulses that respect tx_full, and acknowledges each one.
module dev_dumper_emit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_data,
  input  logic       char_req,
  input  logic       tx_full,
  output logic [7:0] tx_data,
  output logic       tx_push,
  output logic       char_ack
);

  logic gap_r;

  // Push only when the pipe has room and the previous cycle was not a push.
  always_comb begin
    tx_push  = char_req && !tx_full && !gap_r;
    char_ack = tx_push;
    tx_data  = char_req ? char_data : 8'h00;
  end

  // Remember a push so the following cycle is forced idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_r <= 1'b0;
    end else begin
      gap_r <= tx_push;
    end
  end

endmodule

// File: rtl/dev_dumper.sv
// Memory dump engine: reads a byte range from RAM and streams it to the tx pipe
// as uppercase hex pairs separated by spaces, with a newline every line.
// Optional feature macro: DEV_DUMPER_ADDR_PREFIX_EN prefixes each line with "AAAA: ".
module dev_dumper
  import dev_dumper_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int LEN_W          = 16,
  parameter int BYTES_PER_LINE = 16,
  parameter int RAM_LATENCY    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_fetch,
  input  logic [7:0]        ram_data,
  output logic [7:0]        tx_data,
  output logic              tx_push,
  input  logic              tx_full
);

  localparam int LINE_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam int LAT_W  = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
  localparam int DIGITS = ADDR_W / 4;
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`endif

  dumper_state_t     state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic [LINE_W-1:0] line_cnt, line_cnt_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic [7:0]        byte_r, byte_nxt;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
  logic [DIG_W-1:0]  dig_idx, dig_idx_nxt;
  logic [ADDR_W-1:0] addr_shift;
`endif

  logic [7:0] char_data;
  logic       char_req;
  logic       char_ack;
  logic       last_byte;
  logic       line_end;
  dumper_state_t line_start_state;

  assign last_byte = (remaining == LEN_W'(1));
  assign line_end  = (line_cnt == LINE_W'(BYTES_PER_LINE - 1));

`ifdef DEV_DUMPER_ADDR_PREFIX_EN
  assign line_start_state = S_ADDR;
  assign addr_shift       = cur_addr >> (4 * (DIGITS - 1 - int'(dig_idx)));
`else
  assign line_start_state = S_FETCH;
`endif

  // State and datapath registers; reset abandons any dump in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      line_cnt  <= '0;
      lat_cnt   <= '0;
      byte_r    <= 8'h00;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
      dig_idx   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
      line_cnt  <= line_cnt_nxt;
      lat_cnt   <= lat_cnt_nxt;
      byte_r    <= byte_nxt;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
      dig_idx   <= dig_idx_nxt;
`endif
    end
  end

  // Next-state, datapath updates and outputs; emit states wait for the pacer's ack.
  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    line_cnt_nxt  = line_cnt;
    lat_cnt_nxt   = lat_cnt;
    byte_nxt      = byte_r;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
    dig_idx_nxt   = dig_idx;
`endif
    char_data     = 8'h00;
    char_req      = 1'b0;
    ram_fetch     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          cur_addr_nxt  = start_addr;
          remaining_nxt = length;
          line_cnt_nxt  = '0;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
          dig_idx_nxt   = '0;
`endif
          state_nxt     = (length == '0) ? S_DONE : line_start_state;
        end
      end
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
      S_ADDR: begin
        char_req  = 1'b1;
        char_data = nibble_to_ascii(addr_shift[3:0]);
        if (char_ack) begin
          if (dig_idx == DIG_W'(DIGITS - 1)) begin
            state_nxt = S_COLON;
          end else begin
            dig_idx_nxt = dig_idx + DIG_W'(1);
          end
        end
      end
      S_COLON: begin
        char_req  = 1'b1;
        char_data = ASCII_COLON;
        if (char_ack) state_nxt = S_SPACE;
      end
      S_SPACE: begin
        char_req  = 1'b1;
        char_data = ASCII_SPACE;
        if (char_ack) state_nxt = S_FETCH;
      end
`endif
      S_FETCH: begin
        ram_fetch   = 1'b1;
        lat_cnt_nxt = '0;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == LAT_W'(RAM_LATENCY - 1)) begin
          byte_nxt  = ram_data;
          state_nxt = S_EMIT_HI;
        end else begin
          lat_cnt_nxt = lat_cnt + LAT_W'(1);
        end
      end
      S_EMIT_HI: begin
        char_req  = 1'b1;
        char_data = nibble_to_ascii(byte_r[7:4]);
        if (char_ack) state_nxt = S_EMIT_LO;
      end
      S_EMIT_LO: begin
        char_req  = 1'b1;
        char_data = nibble_to_ascii(byte_r[3:0]);
        if (char_ack) state_nxt = S_EMIT_SEP;
      end
      S_EMIT_SEP: begin
        char_req  = 1'b1;
        char_data = (last_byte || line_end) ? ASCII_LF : ASCII_SPACE;
        if (char_ack) begin
          remaining_nxt = remaining - LEN_W'(1);
          cur_addr_nxt  = cur_addr + ADDR_W'(1);
          if (last_byte) begin
            state_nxt = S_DONE;
          end else if (line_end) begin
            line_cnt_nxt = '0;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
            dig_idx_nxt  = '0;
`endif
            state_nxt    = line_start_state;
          end else begin
            line_cnt_nxt = line_cnt + LINE_W'(1);
            state_nxt    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Only present an address while fetching so the bus idles at zero.
  always_comb begin
    ram_addr = ram_fetch ? cur_addr : '0;
  end

  dev_dumper_emit u_emit (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_data (char_data),
    .char_req  (char_req),
    .tx_full   (tx_full),
    .tx_data   (tx_data),
    .tx_push   (tx_push),
    .char_ack  (char_ack)
  );

endmodule

// File: doc/dev_dumper.md
Name: dev_dumper

Overview:
Memory dump engine, the read-side counterpart of the program loader. On a start pulse it reads a byte range from RAM, renders each byte as two uppercase ASCII hex digits, and pushes the characters into the UART tx pipe, space-separated with line breaks. It sits between the RAM mux and the tx pipe mux at top level, and is used to verify loaded images and inspect memory after the CU halts.

Parameters:
ADDR_W, 16, RAM byte-address width; addresses wrap modulo 2^ADDR_W.
LEN_W, 16, width of the byte-count input.
BYTES_PER_LINE, 16, bytes per output line (>=1).
RAM_LATENCY, 1, cycles from ram_fetch/ram_addr to valid ram_data (>=1).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
start_addr  in  ADDR_W  first byte address.
length  in  LEN_W  byte count; 0 means empty dump.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse when dump complete.
ram_addr  out  ADDR_W  byte address; maps to if_dev_ram.addr.
ram_fetch  out  1  fetch strobe; top drives op=RAM_FETCH, size=RAM_BYTE.
ram_data  in  8  fetched byte; data_out[7:0].
tx_data  out  8  character to push.
tx_push  out  1  push strobe to tx pipe push_back.
tx_full  in  1  tx pipe full.

Behaviour:
- Reset (async assert, sync-release expectation): state IDLE; busy, done, tx_push, ram_fetch = 0; ram_addr, tx_data = 0. Reset mid-dump abandons it immediately; no done pulse.
- States: IDLE -> (ADDR_HI..ADDR_LO, COLON, SPACE if feature) -> FETCH -> WAIT -> EMIT_HI -> EMIT_LO -> EMIT_SEP -> FETCH / DONE -> IDLE.
- IDLE: on start, latch start_addr into cur_addr and length into remaining. If length=0 go to DONE; else begin the line.
- FETCH: ram_fetch=1 for exactly one cycle with ram_addr=cur_addr. WAIT then holds RAM_LATENCY-1 further cycles and captures ram_data into byte_r at the end of the latency.
- EMIT_HI/EMIT_LO: push ASCII of byte_r[7:4], then byte_r[3:0]. Nibble 0-9 maps to 0x30-0x39; A-F maps to 0x41-0x46.
- EMIT_SEP: decrement remaining and increment cur_addr (wrap), then choose the separator:
  - remaining now 0: push 0x0A, go to DONE.
  - line count reaches BYTES_PER_LINE: push 0x0A, reset the line count, start a new line.
  - otherwise: push 0x20.
- No trailing space before the newline.
- Push handshake:
  - tx_push is a single-cycle pulse, asserted only if tx_full was 0 in that cycle.
  - At least one idle cycle separates two pushes, so the registered full flag settles.
  - tx_data is valid in the same cycle as tx_push.
  - While tx_full=1 the FSM stalls in the emit state. Characters are never dropped or duplicated.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE. Earliest new start is accepted the following cycle.
- start while busy: ignored, with no effect on the current dump.
- busy=1 in every cycle from the one after acceptance until before DONE.
- Zero length: busy high 0 cycles, done pulse the cycle after start, no pushes, no fetches.

Optional Feature:
Macro DEV_DUMPER_ADDR_PREFIX_EN.
- Defined: each line begins with the line's first address as ADDR_W/4 uppercase hex digits, then ':' (0x3A) and ' ' (0x20), e.g. "0010: ". ADDR_W must be a multiple of 4.
- Undefined: lines contain only the data bytes; the address states are not compiled.

Decomposition:
pkg_dumper:
- state enum typedef.
- ASCII_SPACE=8'h20, ASCII_LF=8'h0A, ASCII_COLON=8'h3A.
- function nibble_to_ascii.
Sub-module dev_dumper_emit:
- Owns the push handshake: accepts char+req, issues spaced tx_push pulses under tx_full, returns ack.
- Keeps the main FSM free of pacing logic.

Test Plan:
1. RAM[0x10..0x12]=12,AB,00; start_addr=0x0010, len=3 -> tx bytes 31 32 20 41 42 20 30 30 0A; one done pulse; 3 fetches, at 0x10, 0x11, 0x12.
2. len=0 -> no ram_fetch, no tx_push, done the cycle after start.
3. BYTES_PER_LINE=4, len=5, bytes 01..05 -> "01 02 03 04\n05\n"; no space before either LF.
4. tx_full held high 100 cycles after the 2nd char -> zero pushes during the hold; full sequence intact afterwards; never two pushes on consecutive cycles.
5. start_addr=0xFFFF, len=2 -> fetch addresses 0xFFFF then 0x0000. With DEV_DUMPER_ADDR_PREFIX_EN, line starts "FFFF: ".
6. rst_n low mid-EMIT_LO -> all outputs 0 asynchronously, no done. start while busy is ignored. Restarting after reset yields a correct dump.
